// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for an external 32-bit ripple ALU: AND/OR/ADD/SUB in one pass,
// SLT in two passes, MUL as 32 shift-add passes. Valid/ready on request and response.
module alu_op_sequencer #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic        alu_binv,
  output logic        alu_sel1,
  output logic        alu_sel0,
  output logic [31:0] alu_less,
  input  logic [31:0] alu_result,
  input  logic        alu_co
);

  typedef enum logic [2:0] {StIdle, StExec, StSlt2, StMul, StDone} state_e;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpSlt = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;

  state_e      state;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  count;
  logic        slt_set;
  logic        slt_ovf;

  // Signed overflow of the a-b pass; corrects the sign bit into a true less-than.
  assign slt_ovf = (op_a[31] != op_b[31]) & (alu_result[31] != op_a[31]);

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_binv = 1'b0;
    alu_sel1 = 1'b0;
    alu_sel0 = 1'b0;
    alu_less = '0;
    case (state)
      StExec: begin
        case (op)
          OpAnd: begin
            alu_a = op_a;
            alu_b = op_b;
          end
          OpOr: begin
            alu_a    = op_a;
            alu_b    = op_b;
            alu_sel0 = 1'b1;
          end
          OpAdd: begin
            alu_a    = op_a;
            alu_b    = op_b;
            alu_sel1 = 1'b1;
          end
          OpSub, OpSlt: begin
            alu_a    = op_a;
            alu_b    = op_b;
            alu_sel1 = 1'b1;
            alu_binv = 1'b1;
            alu_cin  = 1'b1;
          end
          default: ;
        endcase
      end
      StSlt2: begin
        alu_a    = op_a;
        alu_b    = op_b;
        alu_sel1 = 1'b1;
        alu_sel0 = 1'b1;
        alu_binv = 1'b1;
        alu_cin  = 1'b1;
        alu_less = {31'b0, slt_set};
      end
      StMul: begin
        alu_a    = acc;
        alu_b    = mcand;
        alu_sel1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      op         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      slt_set    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            op         <= req_op;
            op_a       <= req_a;
            op_b       <= req_b;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (MUL_EN && req_op == OpMul) begin
              state  <= StMul;
              acc    <= '0;
              mcand  <= req_a;
              mplier <= req_b;
              count  <= '0;
            end else begin
              state <= StExec;
            end
          end
        end
        StExec: begin
          case (op)
            OpAnd, OpOr: begin
              rsp_result <= alu_result;
              state      <= StDone;
              busy       <= 1'b0;
              rsp_valid  <= 1'b1;
            end
            OpAdd, OpSub: begin
              rsp_result <= alu_result;
              rsp_carry  <= alu_co;
              state      <= StDone;
              busy       <= 1'b0;
              rsp_valid  <= 1'b1;
            end
            OpSlt: begin
              slt_set <= alu_result[31] ^ slt_ovf;
              state   <= StSlt2;
            end
            default: begin
              rsp_err   <= 1'b1;
              state     <= StDone;
              busy      <= 1'b0;
              rsp_valid <= 1'b1;
            end
          endcase
        end
        StSlt2: begin
          rsp_result <= alu_result;
          state      <= StDone;
          busy       <= 1'b0;
          rsp_valid  <= 1'b1;
        end
        StMul: begin
          // rsp_carry doubles as the sticky carry accumulator while multiplying.
          if (mplier[0]) begin
            acc       <= alu_result;
            rsp_carry <= rsp_carry | alu_co;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
          if (count == 6'd31) begin
            rsp_result <= mplier[0] ? alu_result : acc;
            state      <= StDone;
            busy       <= 1'b0;
            rsp_valid  <= 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU beside the DUT, directed and random operations
// checked against an arithmetic reference model, plus backpressure and mid-MUL reset.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
  logic        busy;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic        alu_binv;
  logic        alu_sel1;
  logic        alu_sel0;
  logic [31:0] alu_less;
  logic [31:0] alu_result;
  logic        alu_co;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_binv   (alu_binv),
    .alu_sel1   (alu_sel1),
    .alu_sel0   (alu_sel0),
    .alu_less   (alu_less),
    .alu_result (alu_result),
    .alu_co     (alu_co)
  );

  // External ripple ALU, behavioural.
  logic [31:0] alu_bx;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bx  = alu_binv ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_a} + {1'b0, alu_bx} + {32'b0, alu_cin};
    alu_co  = alu_sum[32];
    case ({alu_sel1, alu_sel0})
      2'b00:   alu_result = alu_a & alu_bx;
      2'b01:   alu_result = alu_a | alu_bx;
      2'b10:   alu_result = alu_sum[31:0];
      default: alu_result = alu_less;
    endcase
  end

  // Reference: returns {err, carry, result}.
  function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] acc;
    logic [31:0] m;
    logic        c;
    case (op)
      3'd0: return {2'b00, a & b};
      3'd1: return {2'b00, a | b};
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        return {1'b0, s};
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, s};
      end
      3'd4: return {2'b00, 31'b0, ($signed(a) < $signed(b))};
      3'd5: begin
        acc = '0;
        c   = 1'b0;
        for (int i = 0; i < 32; i++) begin
          if (b[i]) begin
            m   = a << i;
            s   = {1'b0, acc} + {1'b0, m};
            acc = s[31:0];
            c   = c | s[32];
          end
        end
        return {1'b0, c, acc};
      end
      default: return {1'b1, 1'b0, 32'h0};
    endcase
  endfunction

  // Edges after acceptance until rsp_valid is visible; visible after edge T+k means the
  // consumer first samples it at edge T+k+1.
  function automatic int model_lat(input logic [2:0] op);
    if (op == 3'd4) return 2;
    if (op == 3'd5) return 32;
    return 1;
  endfunction

  // Drives one request and returns what the response looked like; leaves it unacknowledged.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic c,
                       output logic e, output bit busy_ok);
    int guard;
    lat     = -1;
    res     = 'x;
    c       = 1'bx;
    e       = 1'bx;
    busy_ok = 1'b1;
    guard   = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (guard >= 50) return;
    for (int k = 1; k <= 40; k++) begin
      if (!busy || req_ready || rsp_valid) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = k;
        res = rsp_result;
        c   = rsp_carry;
        e   = rsp_err;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [101:0] alu_all;
    rst = 1'b1;
    #3;
    for (int pass = 0; pass < 2; pass++) begin
      alu_all = {alu_a, alu_b, alu_less, alu_cin, alu_binv, alu_sel1, alu_sel0};
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_req_ready pass %0d: got %b want 1", pass, req_ready);
      end
      vectors++;
      if ({rsp_valid, rsp_carry, rsp_err, busy} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_flags pass %0d: got %b want 0000", pass,
                 {rsp_valid, rsp_carry, rsp_err, busy});
      end
      vectors++;
      if (rsp_result !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_result pass %0d: got %h want 0", pass, rsp_result);
      end
      vectors++;
      if (alu_all !== '0) begin
        miscompares++;
        $display("FAIL reset_alu_drive pass %0d: got %h want 0", pass, alu_all);
      end
      if (pass == 0) begin
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        e;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        tbl[12];
    int          lat;
    logic [31:0] res;
    logic        c;
    logic        e;
    bit          bok;
    tbl[0]  = '{3'd2, 32'h00000001, 32'h00000003, 32'h00000004, 1'b0, 1'b0, 1};
    tbl[1]  = '{3'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0, 1'b0, 1};
    tbl[2]  = '{3'd1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
    tbl[3]  = '{3'd3, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAB, 1'b0, 1'b0, 1};
    tbl[4]  = '{3'd4, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b0, 2};
    tbl[5]  = '{3'd4, 32'hAAAAAAAA, 32'h55555555, 32'h00000001, 1'b0, 1'b0, 2};
    tbl[6]  = '{3'd4, 32'h00000010, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 2};
    tbl[7]  = '{3'd5, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, 32};
    tbl[8]  = '{3'd5, 32'h00000010, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 32};
    tbl[9]  = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[10] = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[11] = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, res, c, e, bok);
      vectors++;
      if (res !== tbl[i].r) begin
        miscompares++;
        $display("FAIL dir%0d_result op %0d: got %h want %h", i, tbl[i].op, res, tbl[i].r);
      end
      vectors++;
      if ({c, e} !== {tbl[i].c, tbl[i].e}) begin
        miscompares++;
        $display("FAIL dir%0d_carry_err op %0d: got %b%b want %b%b", i, tbl[i].op, c, e,
                 tbl[i].c, tbl[i].e);
      end
      vectors++;
      if (lat != tbl[i].lat) begin
        miscompares++;
        $display("FAIL dir%0d_latency op %0d: got %0d want %0d", i, tbl[i].op, lat, tbl[i].lat);
      end
      vectors++;
      if (!bok) begin
        miscompares++;
        $display("FAIL dir%0d_busy op %0d: got busy/ready wrong while running want busy=1",
                 i, tbl[i].op);
      end
      ack();
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] res;
    logic        c;
    logic        e;
    bit          bok;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [33:0] exp;
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      exp = model(op, a, b);
      issue(op, a, b, lat, res, c, e, bok);
      vectors++;
      if ({e, c, res} !== exp || lat != model_lat(op) || !bok) begin
        miscompares++;
        $display("FAIL rand%0d op %0d a %h b %h: got e%b c%b %h lat %0d want e%b c%b %h lat %0d",
                 n, op, a, b, e, c, res, lat, exp[33], exp[32], exp[31:0], model_lat(op));
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res;
    logic        c;
    logic        e;
    bit          bok;
    bit          got;
    // rsp_ready with nothing pending must do nothing
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_rsp_ready: got ready %b valid %b want 1 0", req_ready, rsp_valid);
    end
    issue(3'd2, 32'h00000001, 32'h00000003, lat, res, c, e, bok);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_a     = 32'h000000F0;
    req_b     = 32'h0000000F;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({rsp_valid, req_ready, busy} !== 3'b100 || rsp_result !== 32'h4) begin
        miscompares++;
        $display("FAIL hold%0d: got v/rdy/busy %b result %h want 100 00000004", k,
                 {rsp_valid, req_ready, busy}, rsp_result);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_handshake: got valid %b ready %b want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL second_accept: got ready %b busy %b want 0 1", req_ready, busy);
    end
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) got = 1'b1;
    end
    vectors++;
    if (!got || rsp_result !== 32'h000000FF || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL second_result: got valid %b result %h want 1 000000ff", got, rsp_result);
    end
    ack();
  endtask

  task automatic test_reset_mid_mul();
    int          lat;
    logic [31:0] res;
    logic        c;
    logic        e;
    bit          bok;
    logic [101:0] alu_all;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_a     = 32'hFFFFFFFF;
    req_b     = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_busy_before_reset: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    alu_all = {alu_a, alu_b, alu_less, alu_cin, alu_binv, alu_sel1, alu_sel0};
    vectors++;
    if ({req_ready, rsp_valid, rsp_carry, rsp_err, busy} !== 5'b10000 || rsp_result !== 0 ||
        alu_all !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy/v/c/e/busy %b result %h alu %h want 10000 0 0",
               {req_ready, rsp_valid, rsp_carry, rsp_err, busy}, rsp_result, alu_all);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_resume: got valid %b busy %b want 0 0", rsp_valid, busy);
    end
    issue(3'd2, 32'h00000001, 32'h00000003, lat, res, c, e, bok);
    vectors++;
    if (res !== 32'h4 || lat != 1 || {c, e} !== 2'b00) begin
      miscompares++;
      $display("FAIL add_after_reset: got %h lat %0d ce %b%b want 00000004 lat 1 ce 00",
               res, lat, c, e);
    end
    ack();
  endtask

  initial begin
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
